// File: rtl/pll_lock_supervisor_if.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor_if
//   Groups the PLL-status inputs and the supervisor outputs into one bundle.
//   All signals belong to the clki domain at the supervisor boundary, except
//   locked and hb_tog, which arrive asynchronously and are synchronised inside.
//
//   locked     PLL lock indication (asynchronous)
//   hb_tog     heartbeat toggle from the 125 MHz domain (asynchronous)
//   clr_fault  single-cycle request to leave FAULT
//   pll_rst    active-high reset to the PLL
//   sys_rdy    clock verified good
//   fault      supervisor is in FAULT
//   loss_cnt   saturating count of losses detected while running
//
//   master: the environment (drives PLL status, observes supervisor)
//   slave : the supervisor itself
// ---------------------------------------------------------------------------
interface pll_lock_supervisor_if;
    logic       locked;
    logic       hb_tog;
    logic       clr_fault;
    logic       pll_rst;
    logic       sys_rdy;
    logic       fault;
    logic [7:0] loss_cnt;

    modport master (
        output locked, hb_tog, clr_fault,
        input  pll_rst, sys_rdy, fault, loss_cnt
    );

    modport slave (
        input  locked, hb_tog, clr_fault,
        output pll_rst, sys_rdy, fault, loss_cnt
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//   Drives the PLL reset, waits for lock, checks that lock is stable, then
//   declares the clock good while watching lock and a heartbeat from the
//   PLL-clocked domain. Repeated failures to lock end in a sticky FAULT that
//   software clears with clr_fault.
//
//   Ports
//     clki  reference clock (also the PLL input); the only clock domain
//     rsti  asynchronous active-low reset, deasserted through a 2-flop sync
//     bus   pll_lock_supervisor_if.slave (status in, supervision out)
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int RST_CYC    = 16,
    parameter int LOCK_TO    = 65536,
    parameter int STABLE_CYC = 1024,
    parameter int HB_TO      = 256,
    parameter int MAX_RETRY  = 3
) (
    input  logic                  clki,
    input  logic                  rsti,
    pll_lock_supervisor_if.slave  bus
);

    // One shared cycle counter serves every state; it must hold the largest
    // terminal count minus one, since it is cleared on every state entry.
    localparam int MAX_A   = (RST_CYC > STABLE_CYC) ? RST_CYC : STABLE_CYC;
    localparam int MAX_B   = (LOCK_TO > HB_TO) ? LOCK_TO : HB_TO;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int RTY_W   = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TO - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] HB_LAST     = CNT_W'(HB_TO - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT   = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {PRST, WLOCK, STAB, RUN, FAULT} state_e;

    // NOTE: reset asserts asynchronously but releases on a clki edge, so no
    // flop below ever sees rst_n rise close to its clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clki or negedge rsti) begin
        if (!rsti) rst_sync_q <= '0;
        else       rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [RTY_W-1:0] retry_q,     retry_d;
    logic [7:0]       loss_q,      loss_d;
    logic [1:0]       lock_sync_q, lock_sync_d;
    logic [2:0]       hb_sync_q,   hb_sync_d;
    logic             pll_rst_q,   pll_rst_d;
    logic             sys_rdy_q,   sys_rdy_d;
    logic             fault_q,     fault_d;

    logic lock_ok;
    logic hb_edge;

    assign lock_ok = lock_sync_q[1];
    // Stage 2 is the synchronised heartbeat; stage 3 is its previous value.
    assign hb_edge = hb_sync_q[1] ^ hb_sync_q[2];

    always_comb begin
        // NOTE: every _d gets a default first, so no path leaves one unassigned
        // and no latch is inferred.
        lock_sync_d = {lock_sync_q[0], bus.locked};
        hb_sync_d   = {hb_sync_q[1:0], bus.hb_tog};
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        retry_d     = retry_q;
        loss_d      = loss_q;

        unique case (state_q)
            PRST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WLOCK;
                    cnt_d   = '0;
                end
            end
            WLOCK: begin
                if (lock_ok) begin
                    state_d = STAB;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    retry_d = retry_q + 1'b1;
                    state_d = (retry_d == RTY_LIMIT) ? FAULT : PRST;
                    cnt_d   = '0;
                end
            end
            STAB: begin
                // A lock drop restarts the lock wait without charging a retry.
                if (!lock_ok) begin
                    state_d = WLOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            RUN: begin
                // Lock loss and heartbeat timeout share one exit, so a
                // simultaneous pair counts as a single loss.
                if (!lock_ok || (!hb_edge && cnt_q == HB_LAST)) begin
                    state_d = PRST;
                    cnt_d   = '0;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end else if (hb_edge) begin
                    cnt_d = '0;
                end
            end
            FAULT: begin
                cnt_d = '0;
                if (bus.clr_fault) begin
                    state_d = PRST;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = PRST;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they change on the same
        // edge as the state register, with no input-to-output path.
        pll_rst_d = (state_d == PRST) || (state_d == FAULT);
        sys_rdy_d = (state_d == RUN);
        fault_d   = (state_d == FAULT);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PRST;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            lock_sync_q <= '0;
            hb_sync_q   <= '0;
            pll_rst_q   <= 1'b1;
            sys_rdy_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            lock_sync_q <= lock_sync_d;
            hb_sync_q   <= hb_sync_d;
            pll_rst_q   <= pll_rst_d;
            sys_rdy_q   <= sys_rdy_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.pll_rst  = pll_rst_q;
    assign bus.sys_rdy  = sys_rdy_q;
    assign bus.fault    = fault_q;
    assign bus.loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
//   Randomised stimulus against a timestamp-based reference model. The model
//   tracks the current phase and the cycle at which it began, and decides
//   transitions from elapsed time against the parameter limits.
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int T_RST  = 16;
    localparam int T_LOCK = 300;
    localparam int T_STAB = 64;
    localparam int T_HB   = 32;
    localparam int T_RTY  = 3;

    logic clki = 1'b0;
    logic rsti = 1'b0;

    pll_lock_supervisor_if bus ();

    pll_lock_supervisor #(
        .RST_CYC    (T_RST),
        .LOCK_TO    (T_LOCK),
        .STABLE_CYC (T_STAB),
        .HB_TO      (T_HB),
        .MAX_RETRY  (T_RTY)
    ) dut (
        .clki (clki),
        .rsti (rsti),
        .bus  (bus)
    );

    always #5 clki = ~clki;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- stimulus drive state ----------------
    logic d_locked  = 1'b0;
    logic d_hb      = 1'b0;
    logic d_clr     = 1'b0;
    bit   hb_on     = 1'b0;
    bit   clr_rand  = 1'b0;
    int   hb_per    = 8;
    int   hb_div    = 0;

    // ---------------- reference model ----------------
    typedef enum {PH_PLLRST, PH_WAITLOCK, PH_STABLE, PH_RUN, PH_FAULT} phase_e;

    phase_e   m_phase  = PH_PLLRST;
    int       m_now    = 0;   // edges seen so far
    int       m_start  = 0;   // edge at which the current phase began
    int       m_hbref  = 0;   // edge of last heartbeat (or RUN entry)
    int       m_rs     = 0;   // reset-release progress, 2 = running
    int       m_retry  = 0;
    int       m_loss   = 0;
    bit [1:0] m_ls     = '0;
    bit [2:0] m_hbs    = '0;
    bit       exp_pll  = 1'b1;
    bit       exp_rdy  = 1'b0;
    bit       exp_flt  = 1'b0;

    task automatic enter(input phase_e p);
        m_phase = p;
        m_start = m_now;
    endtask

    task automatic model_step();
        bit lock_ok;
        bit hb_edge;
        int el;
        m_now++;
        if (!rsti) begin
            m_rs = 0; m_retry = 0; m_loss = 0; m_ls = '0; m_hbs = '0;
            enter(PH_PLLRST);
        end else if (m_rs < 2) begin
            // core still held while the reset release crosses into clki
            m_rs++;
            enter(PH_PLLRST);
        end else begin
            lock_ok = m_ls[1];
            hb_edge = m_hbs[1] ^ m_hbs[2];
            m_ls    = {m_ls[0], d_locked};
            m_hbs   = {m_hbs[1:0], d_hb};
            el      = m_now - m_start;
            case (m_phase)
                PH_PLLRST:   if (el == T_RST) enter(PH_WAITLOCK);
                PH_WAITLOCK: begin
                    if (lock_ok) enter(PH_STABLE);
                    else if (el == T_LOCK) begin
                        m_retry++;
                        enter((m_retry == T_RTY) ? PH_FAULT : PH_PLLRST);
                    end
                end
                PH_STABLE: begin
                    if (!lock_ok) enter(PH_WAITLOCK);
                    else if (el == T_STAB) begin
                        m_retry = 0;
                        enter(PH_RUN);
                        m_hbref = m_now;
                    end
                end
                PH_RUN: begin
                    if (hb_edge) m_hbref = m_now;
                    if (!lock_ok || (m_now - m_hbref == T_HB)) begin
                        if (m_loss < 255) m_loss++;
                        enter(PH_PLLRST);
                    end
                end
                PH_FAULT: begin
                    if (d_clr) begin
                        m_retry = 0;
                        enter(PH_PLLRST);
                    end
                end
                default: enter(PH_PLLRST);
            endcase
        end
        exp_pll = (m_phase == PH_PLLRST) || (m_phase == PH_FAULT);
        exp_rdy = (m_phase == PH_RUN);
        exp_flt = (m_phase == PH_FAULT);
    endtask

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic tick();
        if (hb_on) begin
            hb_div++;
            if (hb_div >= hb_per) begin
                hb_div = 0;
                d_hb   = ~d_hb;
                hb_per = $urandom_range(3, 8);
            end
        end
        if (clr_rand && $urandom_range(0, 31) == 0) d_clr = 1'b1;
        bus.locked    = d_locked;
        bus.hb_tog    = d_hb;
        bus.clr_fault = d_clr;
        model_step();
        @(negedge clki);
        check("pll_rst",  32'(bus.pll_rst),  32'(exp_pll));
        check("sys_rdy",  32'(bus.sys_rdy),  32'(exp_rdy));
        check("fault",    32'(bus.fault),    32'(exp_flt));
        check("loss_cnt", 32'(bus.loss_cnt), 32'(m_loss));
        d_clr = 1'b0;
    endtask

    task automatic run_until_rdy(input string tag, input int budget);
        int n = 0;
        while (!bus.sys_rdy && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.sys_rdy), 32'd1);
    endtask

    initial begin
        int  n;
        int  hi;
        int  base;
        int  falls;
        bit  seen_low;
        bit  prev;

        bus.locked    = 1'b0;
        bus.hb_tog    = 1'b0;
        bus.clr_fault = 1'b0;

        // ---- reset held ----
        rsti  = 1'b0;
        hb_on = 1'b1;
        repeat (5) tick();
        check("rst_pll_rst", 32'(bus.pll_rst), 32'd1);
        check("rst_loss",    32'(bus.loss_cnt), 32'd0);

        // ---- startup: locked low 100 cycles, then high ----
        rsti     = 1'b1;
        hi       = 0;
        seen_low = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!seen_low) begin
                if (bus.pll_rst) hi++;
                else             seen_low = 1'b1;
            end
        end
        // one extra sample: the first edge after release is still inside the sync
        check("startup_pulse", 32'(hi), 32'(T_RST + 1));
        clr_rand = 1'b1;
        d_locked = 1'b1;
        n = 0;
        while (!bus.sys_rdy && n < T_STAB + 50) begin
            tick();
            n++;
        end
        check("rdy_latency",  32'(n), 32'(T_STAB + 3));
        check("startup_loss", 32'(bus.loss_cnt), 32'd0);

        // ---- lock loss in RUN ----
        repeat ($urandom_range(10, 40)) tick();
        d_locked = 1'b0;
        n = 0;
        while (bus.sys_rdy && n < 10) begin
            tick();
            n++;
        end
        check("loss_latency", 32'(n), 32'd3);
        check("loss_pll_rst", 32'(bus.pll_rst), 32'd1);
        check("loss_cnt_1",   32'(bus.loss_cnt), 32'd1);
        repeat ($urandom_range(0, 3)) tick();
        d_locked = 1'b1;
        run_until_rdy("relock", 400);

        // ---- lock glitch half way through the stable window ----
        d_locked = 1'b0;
        repeat (3) tick();
        d_locked = 1'b1;
        n = 0;
        while (!(m_phase == PH_STABLE && m_now - m_start == T_STAB / 2) && n < 400) begin
            tick();
            n++;
        end
        check("reach_stab", 32'(m_phase == PH_STABLE), 32'd1);
        d_locked = 1'b0;
        tick();
        d_locked = 1'b1;
        n = 0;
        while (!bus.sys_rdy && n < 2 * T_STAB) begin
            tick();
            n++;
        end
        check("glitch_restart", 32'(n), 32'(T_STAB + 3));
        check("loss_cnt_2",     32'(bus.loss_cnt), 32'd2);

        // ---- heartbeat stall ----
        repeat ($urandom_range(5, 20)) tick();
        base  = m_loss;
        hb_on = 1'b0;
        n = 0;
        while (bus.sys_rdy && n < T_HB + 20) begin
            tick();
            n++;
        end
        check("hb_stall_bound", 32'(n <= T_HB + 3), 32'd1);
        check("hb_stall_loss",  32'(bus.loss_cnt), 32'(base + 1));
        hb_on = 1'b1;
        run_until_rdy("hb_recover", 400);

        // ---- heartbeat timeout and lock drop on the same edge ----
        repeat ($urandom_range(5, 20)) tick();
        base  = m_loss;
        hb_on = 1'b0;
        repeat (4) tick();
        n = 0;
        // a lock drop driven now reaches the state logic three edges later
        while (m_now + 3 != m_hbref + T_HB && n < 40) begin
            tick();
            n++;
        end
        d_locked = 1'b0;
        n = 0;
        while (bus.sys_rdy && n < 10) begin
            tick();
            n++;
        end
        check("coincide_drop", 32'(bus.sys_rdy), 32'd0);
        check("coincide_loss", 32'(bus.loss_cnt), 32'(base + 1));
        repeat (2) tick();
        d_locked = 1'b1;
        hb_on    = 1'b1;
        run_until_rdy("coincide_recover", 400);

        // ---- saturation ----
        for (int k = 0; k < 260; k++) begin
            repeat ($urandom_range(1, 6)) tick();
            d_locked = 1'b0;
            repeat ($urandom_range(3, 5)) tick();
            d_locked = 1'b1;
            run_until_rdy("sat_relock", 300);
        end
        check("loss_sat", 32'(bus.loss_cnt), 32'd255);

        // ---- asynchronous reset in the middle of WLOCK ----
        clr_rand = 1'b0;
        d_locked = 1'b0;
        n = 0;
        while (m_phase != PH_WAITLOCK && n < 60) begin
            tick();
            n++;
        end
        check("reach_wlock", 32'(m_phase == PH_WAITLOCK), 32'd1);
        repeat ($urandom_range(5, 100)) tick();
        rsti = 1'b0;
        #1;
        check("async_pll_rst", 32'(bus.pll_rst),  32'd1);
        check("async_sys_rdy", 32'(bus.sys_rdy),  32'd0);
        check("async_fault",   32'(bus.fault),    32'd0);
        check("async_loss",    32'(bus.loss_cnt), 32'd0);
        repeat (3) tick();

        // ---- never lock: three reset pulses, then FAULT ----
        rsti  = 1'b1;
        falls = 0;
        prev  = bus.pll_rst;
        n = 0;
        while (!bus.fault && n < 2000) begin
            tick();
            if (prev && !bus.pll_rst) falls++;
            prev = bus.pll_rst;
            n++;
        end
        check("prst_pulses", 32'(falls), 32'd3);
        check("fault_set",   32'(bus.fault), 32'd1);
        check("fault_pll",   32'(bus.pll_rst), 32'd1);
        repeat (5) tick();
        d_clr = 1'b1;
        tick();
        check("clr_fault", 32'(bus.fault), 32'd0);
        n = 0;
        while (bus.pll_rst && n < T_RST + 10) begin
            n++;
            tick();
        end
        check("clr_prst_len", 32'(n), 32'(T_RST));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
